// File: rtl/multi_dataflow_engine_gen_pkg.sv
// Shared types for the multi-stream dataflow engine.
// Control/flag bundles are sized by the package lane constants.
package multi_dataflow_gen_package;

  localparam int unsigned N_IN      = 2;
  localparam int unsigned N_OUT     = 2;
  localparam int unsigned CNT_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    WAIT_K,
    DONE
  } engine_state_t;

  typedef struct packed {
    logic                                start;
    logic                                clear;
    logic [N_OUT-1:0][CNT_WIDTH-1:0]     len_out;
  } ctrl_engine_gen_t;

  typedef struct packed {
    logic                                ready;
    logic                                busy;
    logic                                done;
    logic [N_OUT-1:0][CNT_WIDTH-1:0]     cnt_out;
    logic [CNT_WIDTH-1:0]                cycles;
  } flags_engine_gen_t;

endpackage

// File: rtl/multi_dataflow_engine_gen_stream_intf.sv
// Valid/ready data stream with byte strobes.
// source drives valid/data/strb, sink drives ready.
interface dataflow_stream_intf #(
  parameter int unsigned DATA_WIDTH = 32
) ();

  logic                    valid;
  logic                    ready;
  logic [DATA_WIDTH-1:0]   data;
  logic [DATA_WIDTH/8-1:0] strb;

  modport source (
    output valid, data, strb,
    input  ready
  );

  modport sink (
    input  valid, data, strb,
    output ready
  );

endinterface

// File: rtl/multi_dataflow_engine_gen_out_counter.sv
// Per-output beat counter, saturating at the programmed length.
// complete looks ahead by including this cycle's handshake.
module dataflow_out_counter #(
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clear,
  input  logic                 load0,
  input  logic                 hs,
  input  logic [CNT_WIDTH-1:0] len,
  output logic [CNT_WIDTH-1:0] cnt,
  output logic                 complete
);

  logic [CNT_WIDTH-1:0] cnt_q;
  logic [CNT_WIDTH-1:0] cnt_d;

  // next count: one more per accepted beat, never past len
  always_comb begin
    cnt_d = cnt_q;
    if (hs && (cnt_q < len)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // count register, zeroed on clear or at run start
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (clear || load0) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt      = cnt_q;
  assign complete = (cnt_d == len);

endmodule

// File: rtl/multi_dataflow_engine_gen.sv
// Dataflow engine: gates kernel streams, sequences a run,
// and counts output beats against programmed lengths.
module multi_dataflow_engine_gen #(
  parameter int unsigned N_IN       = 2,
  parameter int unsigned N_OUT      = 1,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic test_mode_i,
  dataflow_stream_intf.sink   in_i   [N_IN],
  dataflow_stream_intf.source kin_o  [N_IN],
  dataflow_stream_intf.sink   kout_i [N_OUT],
  dataflow_stream_intf.source out_o  [N_OUT],
  input  multi_dataflow_gen_package::ctrl_engine_gen_t  ctrl_i,
  output logic k_start_o,
  input  logic k_done_i,
  input  logic k_idle_i,
  output multi_dataflow_gen_package::flags_engine_gen_t flags_o
);

  import multi_dataflow_gen_package::*;

  engine_state_t        state_q;
  engine_state_t        state_d;
  logic                 load0;
  logic                 run;
  logic                 k_start_q;
  logic                 ready_q;
  logic                 all_complete;
  logic [N_OUT-1:0]     open_out;
  logic [N_OUT-1:0]     hs;
  logic [N_OUT-1:0]     complete;
  logic [CNT_WIDTH-1:0] cnt [N_OUT];
  logic [CNT_WIDTH-1:0] cycles_q;

  logic unused_test_mode;
  logic unused_len;

  assign unused_test_mode = test_mode_i;
  assign unused_len       = ^ctrl_i.len_out;

  assign run          = (state_q == RUN);
  assign all_complete = &complete;

  // next state; clear overrides every transition
  always_comb begin
    state_d = state_q;
    load0   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (ctrl_i.start) begin
          state_d = RUN;
          load0   = 1'b1;
        end
      end
      RUN: begin
        if (all_complete) begin
          state_d = WAIT_K;
        end
      end
      WAIT_K: begin
        if (k_done_i || k_idle_i) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (ctrl_i.clear) begin
      state_d = IDLE;
      load0   = 1'b0;
    end
  end

  // state, kernel start pulse and registered idle flag
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      k_start_q <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_start_q <= load0;
      ready_q   <= (state_q == IDLE);
    end
  end

  // run-cycle counter, saturating at all-ones
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cycles_q <= '0;
    end else if (ctrl_i.clear || load0) begin
      cycles_q <= '0;
    end else if ((run || state_q == WAIT_K) && cycles_q != '1) begin
      cycles_q <= cycles_q + 1'b1;
    end
  end

  for (genvar i = 0; i < N_IN; i++) begin : g_in
    assign kin_o[i].valid = run & in_i[i].valid;
    assign kin_o[i].data  = in_i[i].data;
    assign kin_o[i].strb  = in_i[i].strb;
    assign in_i[i].ready  = run & kin_o[i].ready;
  end

  for (genvar j = 0; j < N_OUT; j++) begin : g_out
    logic unused_strb;

    assign unused_strb = ^kout_i[j].strb;
    assign open_out[j] = run && (cnt[j] < ctrl_i.len_out[j]);

    assign out_o[j].valid  = open_out[j] & kout_i[j].valid;
    assign out_o[j].data   = kout_i[j].data;
    assign out_o[j].strb   = '1;
    assign kout_i[j].ready = open_out[j] & out_o[j].ready;

    assign hs[j] = open_out[j] & kout_i[j].valid & out_o[j].ready;

    dataflow_out_counter #(
      .CNT_WIDTH (CNT_WIDTH)
    ) i_cnt (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .clear    (ctrl_i.clear),
      .load0    (load0),
      .hs       (hs[j]),
      .len      (ctrl_i.len_out[j]),
      .cnt      (cnt[j]),
      .complete (complete[j])
    );
  end

  assign k_start_o = k_start_q;

  // status bundle; lanes beyond N_OUT read zero
  always_comb begin
    flags_o        = '0;
    flags_o.ready  = ready_q;
    flags_o.busy   = (state_q != IDLE);
    flags_o.done   = (state_q == DONE);
    flags_o.cycles = cycles_q;
    for (int j = 0; j < N_OUT; j++) begin
      flags_o.cnt_out[j] = cnt[j];
    end
  end

endmodule

// File: tb/tb_multi_dataflow_engine_gen.sv
// Scoreboard bench for multi_dataflow_engine_gen.
// Output beats and done snapshots are checked by monitors.
module tb_multi_dataflow_engine_gen;
  import multi_dataflow_gen_package::*;

  localparam int NI = 2;
  localparam int NO = 2;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic test_mode = 1'b0;
  logic k_start;
  logic k_done = 1'b0;
  logic k_idle = 1'b0;
  ctrl_engine_gen_t  ctrl;
  flags_engine_gen_t flags;

  dataflow_stream_intf #(.DATA_WIDTH(DW)) in_s   [NI] ();
  dataflow_stream_intf #(.DATA_WIDTH(DW)) kin_s  [NI] ();
  dataflow_stream_intf #(.DATA_WIDTH(DW)) kout_s [NO] ();
  dataflow_stream_intf #(.DATA_WIDTH(DW)) out_s  [NO] ();

  always #5 clk = ~clk;

  multi_dataflow_engine_gen #(
    .N_IN       (NI),
    .N_OUT      (NO),
    .DATA_WIDTH (DW),
    .CNT_WIDTH  (16)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .test_mode_i (test_mode),
    .in_i        (in_s),
    .kin_o       (kin_s),
    .kout_i      (kout_s),
    .out_o       (out_s),
    .ctrl_i      (ctrl),
    .k_start_o   (k_start),
    .k_done_i    (k_done),
    .k_idle_i    (k_idle),
    .flags_o     (flags)
  );

  typedef struct {
    int c0;
    int c1;
    int cyc;
    bit use_cyc;
  } done_t;

  int checks = 0;
  int errors = 0;
  done_t exp_done [$];
  logic [31:0] exp_q [NO][$];
  int epoch = 0;
  int k_n [NO];
  bit rdy_rand = 1'b0;

  function automatic logic [31:0] beat(int j, int k);
    return 32'hA000_0000 | (j << 16) | k;
  endfunction

  task automatic check(string name, logic [31:0] act,
                       logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic arm(int l0, int l1, int n0, int n1,
                     int a0, int a1, bit rnd);
    ctrl.len_out[0] = 16'(l0);
    ctrl.len_out[1] = 16'(l1);
    k_n[0] = n0;
    k_n[1] = n1;
    rdy_rand = rnd;
    epoch++;
    for (int k = 0; k < a0; k++) exp_q[0].push_back(beat(0, k));
    for (int k = 0; k < a1; k++) exp_q[1].push_back(beat(1, k));
  endtask

  task automatic push_done(int c0, int c1, int cyc, bit use_cyc);
    done_t d;
    d.c0 = c0;
    d.c1 = c1;
    d.cyc = cyc;
    d.use_cyc = use_cyc;
    exp_done.push_back(d);
  endtask

  task automatic wait_done(int budget, output int n);
    n = 0;
    while (flags.done !== 1'b1 && n < budget) begin
      step();
      n++;
    end
    if (flags.done !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL wait_done timeout got 0 required 1");
    end
  endtask

  for (genvar g = 0; g < NO; g++) begin : g_k
    logic hs_seen = 1'b0;
    int idx = 0;
    int last = 0;

    always @(negedge clk) begin
      logic [31:0] e;
      hs_seen = (out_s[g].valid === 1'b1) && (out_s[g].ready === 1'b1);
      if (hs_seen) begin
        if (exp_q[g].size() == 0) begin
          checks++;
          errors++;
          $display("FAIL out%0d extra beat got %0h required none",
                   g, out_s[g].data);
        end else begin
          e = exp_q[g].pop_front();
          check($sformatf("out%0d data", g), out_s[g].data, e);
          check($sformatf("out%0d strb", g),
                32'(out_s[g].strb), 32'hF);
        end
      end
    end

    always @(posedge clk) begin
      #2;
      if (epoch != last) begin
        last = epoch;
        idx = 0;
      end else if (hs_seen) begin
        idx++;
      end
      kout_s[g].valid = (idx < k_n[g]);
      kout_s[g].data  = beat(g, idx);
      kout_s[g].strb  = '0;
      out_s[g].ready  = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  always @(negedge clk) begin
    done_t e;
    if (flags.done === 1'b1) begin
      if (exp_done.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL done unexpected pulse got 1 required 0");
      end else begin
        e = exp_done.pop_front();
        check("done cnt0", 32'(flags.cnt_out[0]), e.c0);
        check("done cnt1", 32'(flags.cnt_out[1]), e.c1);
        if (e.use_cyc) begin
          check("done cycles", 32'(flags.cycles), e.cyc);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    ctrl = '0;
    k_n[0] = 0;
    k_n[1] = 0;
    in_s[0].valid = 1'b1;
    in_s[0].data  = 32'h1111_0000;
    in_s[0].strb  = '1;
    in_s[1].valid = 1'b0;
    in_s[1].data  = 32'h2222_0000;
    in_s[1].strb  = '1;
    kin_s[0].ready = 1'b1;
    kin_s[1].ready = 1'b0;

    arm(8, 0, 8, 0, 8, 0, 1'b0);
    push_done(8, 0, 9, 1'b1);
    repeat (2) step();
    check("rst ready", 32'(flags.ready), 0);
    check("rst busy", 32'(flags.busy), 0);
    check("rst done", 32'(flags.done), 0);
    check("rst kstart", 32'(k_start), 0);
    check("rst cycles", 32'(flags.cycles), 0);
    check("rst in0 ready", 32'(in_s[0].ready), 0);
    check("rst out0 valid", 32'(out_s[0].valid), 0);
    rst_n = 1'b1;
    step();
    check("idle ready", 32'(flags.ready), 1);
    check("idle busy", 32'(flags.busy), 0);
    check("idle kin0 valid", 32'(kin_s[0].valid), 0);
    check("idle in0 ready", 32'(in_s[0].ready), 0);
    check("idle out0 valid", 32'(out_s[0].valid), 0);

    ctrl.start = 1'b1;
    step();
    ctrl.start = 1'b0;
    check("t1 kstart", 32'(k_start), 1);
    check("t1 busy", 32'(flags.busy), 1);
    check("t1 kin0 valid", 32'(kin_s[0].valid), 1);
    check("t1 kin0 data", kin_s[0].data, 32'h1111_0000);
    check("t1 in0 ready", 32'(in_s[0].ready), 1);
    check("t1 in1 ready", 32'(in_s[1].ready), 0);
    n = 0;
    do begin
      step();
      n++;
      if (n == 1) check("t1 kstart low", 32'(k_start), 0);
      if (n == 8) k_idle = 1'b1;
    end while (flags.done !== 1'b1 && n < 30);
    check("t1 done latency", n, 9);
    step();
    check("t1 idle busy", 32'(flags.busy), 0);
    check("t1 idle done", 32'(flags.done), 0);
    check("t1 ready lag", 32'(flags.ready), 0);
    step();
    check("t1 ready back", 32'(flags.ready), 1);
    check("t1 cnt hold", 32'(flags.cnt_out[0]), 8);
    check("t1 cycles hold", 32'(flags.cycles), 9);
    check("t1 beats left", exp_q[0].size(), 0);
    k_idle = 1'b0;

    arm(4, 6, 10, 10, 4, 6, 1'b1);
    push_done(4, 6, 0, 1'b0);
    k_idle = 1'b1;
    step();
    ctrl.start = 1'b1;
    step();
    ctrl.start = 1'b0;
    wait_done(300, n);
    repeat (3) step();
    check("t2 cnt0", 32'(flags.cnt_out[0]), 4);
    check("t2 cnt1", 32'(flags.cnt_out[1]), 6);
    check("t2 beats0 left", exp_q[0].size(), 0);
    check("t2 beats1 left", exp_q[1].size(), 0);
    k_idle = 1'b0;

    arm(0, 0, 3, 3, 0, 0, 1'b0);
    push_done(0, 0, 5, 1'b1);
    step();
    ctrl.start = 1'b1;
    step();
    ctrl.start = 1'b0;
    check("t3 busy run", 32'(flags.busy), 1);
    step();
    check("t3 busy waitk", 32'(flags.busy), 1);
    check("t3 cycles", 32'(flags.cycles), 1);
    check("t3 out0 valid", 32'(out_s[0].valid), 0);
    check("t3 kout1 ready", 32'(kout_s[1].ready), 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("t3 hold waitk", 32'(flags.done), 0);
    end
    k_done = 1'b1;
    step();
    k_done = 1'b0;
    check("t3 done", 32'(flags.done), 1);
    step();
    check("t3 done once", 32'(flags.done), 0);

    arm(8, 0, 8, 0, 4, 0, 1'b0);
    k_idle = 1'b1;
    step();
    ctrl.start = 1'b1;
    step();
    ctrl.start = 1'b0;
    repeat (3) step();
    check("t4 cnt before clear", 32'(flags.cnt_out[0]), 3);
    ctrl.clear = 1'b1;
    step();
    ctrl.clear = 1'b0;
    check("t4 busy", 32'(flags.busy), 0);
    check("t4 cnt", 32'(flags.cnt_out[0]), 0);
    check("t4 cycles", 32'(flags.cycles), 0);
    check("t4 out0 valid", 32'(out_s[0].valid), 0);
    check("t4 kstart", 32'(k_start), 0);
    repeat (2) step();
    check("t4 ready", 32'(flags.ready), 1);
    check("t4 beats left", exp_q[0].size(), 0);
    arm(8, 0, 8, 0, 8, 0, 1'b0);
    push_done(8, 0, 9, 1'b1);
    step();
    ctrl.start = 1'b1;
    step();
    ctrl.start = 1'b0;
    wait_done(40, n);
    check("t4 rerun latency", n, 9);
    step();
    check("t4 rerun beats", exp_q[0].size(), 0);

    arm(4, 0, 4, 0, 4, 0, 1'b0);
    push_done(4, 0, 5, 1'b1);
    step();
    ctrl.start = 1'b1;
    step();
    check("t5 kstart", 32'(k_start), 1);
    step();
    ctrl.start = 1'b0;
    check("t5 kstart once", 32'(k_start), 0);
    check("t5 busy", 32'(flags.busy), 1);
    check("t5 ready", 32'(flags.ready), 0);
    wait_done(30, n);
    check("t5 done latency", n, 4);
    for (int i = 0; i < 6; i++) begin
      step();
      check("t5 no restart", 32'(k_start), 0);
    end
    check("t5 idle", 32'(flags.busy), 0);
    check("done queue", exp_done.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multi_dataflow_engine_gen.md
# multi_dataflow_engine_gen

Parametrised HWPE engine sitting between the streamer and the kernel adapter. It gates N_IN input streams and N_OUT output streams, runs a start/run/drain/done FSM, and counts output handshakes against programmed per-output lengths. It reports done, ready, per-output counts and run-cycle count to the controller FSM, and forces output strobes to all-ones.

## Interface
Parameters:
- N_IN, 2, number of input streams
- N_OUT, 1, number of output streams
- DATA_WIDTH, 32, stream data width
- CNT_WIDTH, 16, width of length, count and cycle counters

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- test_mode_i  in  1  passed through, no functional effect
- in_i[N_IN]  sink  DATA_WIDTH  input streams from the streamer
- kin_o[N_IN]  source  DATA_WIDTH  input streams to the kernel adapter
- kout_i[N_OUT]  sink  DATA_WIDTH  output streams from the kernel adapter
- out_o[N_OUT]  source  DATA_WIDTH  output streams to the streamer; strb always '1
- ctrl_i  in  ctrl_engine_gen_t  fields: start, clear, len_out[N_OUT] (CNT_WIDTH each)
- k_start_o  out  1  one-cycle kernel start pulse
- k_done_i, k_idle_i  in  1  kernel adapter status
- flags_o  out  flags_engine_gen_t  fields: ready, busy, done, cnt_out[N_OUT], cycles

## Operation
- FSM states: IDLE, RUN, WAIT_K, DONE.
- IDLE -> RUN when ctrl_i.start=1. On this transition, all cnt_out and cycles load 0.
- RUN -> WAIT_K when every output is complete. Output j is complete when cnt_out[j]==len_out[j], evaluated including a handshake in the current cycle.
- WAIT_K -> DONE when k_done_i | k_idle_i.
- DONE -> IDLE unconditionally.
- ctrl_i.clear is synchronous and has priority over everything:
  - any state -> IDLE
  - counters -> 0
  - k_start_o -> 0
- ctrl_i.start outside IDLE: ignored.
- len_out is sampled every cycle; it must be stable from start to done.
- Input gating:
  - in RUN, kin_o[i].valid/data = in_i[i].valid/data and in_i[i].ready = kin_o[i].ready (combinational);
  - otherwise kin_o valid=0 and in_i ready=0.
- Output gating, per output j:
  - in RUN and cnt_out[j]<len_out[j], out_o[j] mirrors kout_i[j] and kout_i[j].ready = out_o[j].ready;
  - otherwise out_o[j].valid=0 and kout_i[j].ready=0.
  - No output can ever exceed its length.
- cnt_out[j] increments on out_o[j].valid & out_o[j].ready. It saturates at len_out[j] and holds after DONE until clear or the next start.
- cycles increments every RUN or WAIT_K cycle and saturates at 2^CNT_WIDTH-1.
- len_out[j]=0 makes output j complete immediately. All lengths zero: one RUN cycle, then WAIT_K.

## Timing
- Reset values:
  - state=IDLE
  - k_start_o=0
  - flags_o.done=0, busy=0, ready=0
  - cnt_out=0, cycles=0
- flags_o.ready is registered: it equals (state==IDLE) delayed one cycle, so it reads 1 from the first cycle after reset release.
- busy is combinational: 1 in RUN, WAIT_K and DONE.
- Start sampled at cycle t: state=RUN and k_start_o=1 at t+1 only; streams open at t+1.
- Final output handshake at cycle t: WAIT_K at t+1. If k_done_i|k_idle_i at t+1, DONE at t+2 with flags_o.done=1 for exactly that cycle, and IDLE at t+3.
- Stream pass-through adds zero latency and no buffering. valid must not depend on ready.
- Reset mid-operation immediately returns all outputs to their reset values. Clear mid-RUN drops in-flight beats, because ready is deasserted the next cycle.

## Structure
- Package multi_dataflow_gen_package holds:
  - ctrl_engine_gen_t and flags_engine_gen_t (parametrised via package constants N_IN, N_OUT, CNT_WIDTH)
  - state enum engine_state_t
- Sub-module dataflow_out_counter, one instance per output. Inputs: clk, rst_ni, clear, load0, hs, len. Outputs: cnt, complete. It holds the saturating counter and the complete compare.

## Test plan
- Reset and idle: release reset -> ready=1 at the next cycle, busy=0, done=0, all streams closed (in_i.ready=0, out_o.valid=0).
- Basic run, N_OUT=1, len=8:
  - stimulus: start, kernel emits 8 beats with out ready always 1, k_idle_i=1 after the last beat;
  - response: k_start_o pulses one cycle after start, cnt_out=8, done pulses two cycles after the 8th handshake, cycles=9.
- Back-pressure and over-production, N_OUT=2, len={4,6}:
  - stimulus: random out ready, kernel offers 10 beats on each output;
  - response: out0 closes after 4, out1 after 6; done only after both; no counter exceeds its length.
- Zero length: len=0 -> RUN for 1 cycle, then WAIT_K; done follows k_done_i with cnt_out=0.
- Clear mid-run: clear after 3 of 8 beats -> IDLE next cycle, cnt_out=0, no done pulse; a new start runs to completion normally.
- Start while busy: second start pulse in RUN is ignored; single k_start_o pulse, single done.
